// File: rtl/approx_err_monitor.sv
// Error-statistics collector behind a WIDTH-bit approximate adder: count, error count, max and sum of |approx-exact|.
// Optional worst-case-sample capture (wce_a/wce_b/wce_approx) under APPROX_ERR_MONITOR_WCE_EN.
module approx_err_monitor #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH:0]   in_approx,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [WIDTH:0]   max_abs_err,
  output logic [ACC_W-1:0] sum_abs_err,
  output logic             acc_ovf
`ifdef APPROX_ERR_MONITOR_WCE_EN
  ,
  output logic [WIDTH-1:0] wce_a,
  output logic [WIDTH-1:0] wce_b,
  output logic [WIDTH:0]   wce_approx
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state;
  logic [CNT_W-1:0] acc_cnt, num_lat;
  // vld_pipe[0]: stage 1 holds a sample; vld_pipe[1]: stage 2 folded one in last edge
  logic [1:0]       vld_pipe;
  logic [WIDTH:0]   s1_exact, s1_approx;
`ifdef APPROX_ERR_MONITOR_WCE_EN
  logic [WIDTH-1:0] s1_a, s1_b;
`endif

  logic           start_ok, accept, last;
  logic [WIDTH:0] abs_err;
  logic [ACC_W:0] sum_ext;

  assign start_ok = start && (state == S_IDLE || state == S_DONE);
  assign in_ready = (state == S_RUN) && (acc_cnt < num_lat);
  assign accept   = in_valid && in_ready;
  assign last     = accept && (acc_cnt + CNT_W'(1) == num_lat);
  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);

  assign abs_err = (s1_approx >= s1_exact) ? s1_approx - s1_exact : s1_exact - s1_approx;
  assign sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(abs_err);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      acc_cnt <= '0;
      num_lat <= '0;
    end else begin
      if (accept) acc_cnt <= acc_cnt + CNT_W'(1);
      case (state)
        S_IDLE, S_DONE: if (start_ok) begin
          acc_cnt <= '0;
          num_lat <= num_samples;
          state   <= (num_samples == '0) ? S_DONE : S_RUN;
        end
        S_RUN:   if (last) state <= S_DRAIN;
        // last sample has been folded and stage 1 is empty
        S_DRAIN: if (vld_pipe == 2'b10) state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      s1_exact  <= '0;
      s1_approx <= '0;
`ifdef APPROX_ERR_MONITOR_WCE_EN
      s1_a      <= '0;
      s1_b      <= '0;
`endif
    end else begin
      vld_pipe <= {vld_pipe[0], accept};
      if (accept) begin
        s1_exact  <= {1'b0, in_a} + {1'b0, in_b};
        s1_approx <= in_approx;
`ifdef APPROX_ERR_MONITOR_WCE_EN
        s1_a      <= in_a;
        s1_b      <= in_b;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      acc_ovf     <= 1'b0;
`ifdef APPROX_ERR_MONITOR_WCE_EN
      wce_a       <= '0;
      wce_b       <= '0;
      wce_approx  <= '0;
`endif
    end else if (start_ok) begin
      sample_cnt  <= '0;
      err_cnt     <= '0;
      max_abs_err <= '0;
      sum_abs_err <= '0;
      acc_ovf     <= 1'b0;
`ifdef APPROX_ERR_MONITOR_WCE_EN
      wce_a       <= '0;
      wce_b       <= '0;
      wce_approx  <= '0;
`endif
    end else if (vld_pipe[0]) begin
      sample_cnt <= sample_cnt + CNT_W'(1);
      if (abs_err != '0) err_cnt <= err_cnt + CNT_W'(1);
      if (abs_err > max_abs_err) begin
        max_abs_err <= abs_err;
`ifdef APPROX_ERR_MONITOR_WCE_EN
        wce_a      <= s1_a;
        wce_b      <= s1_b;
        wce_approx <= s1_approx;
`endif
      end
      if (sum_ext[ACC_W]) begin
        sum_abs_err <= '1;
        acc_ovf     <= 1'b1;
      end else begin
        sum_abs_err <= sum_ext[ACC_W-1:0];
      end
    end
  end

endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor: default instance plus an ACC_W=17 instance for saturation.
module tb_approx_err_monitor;
  localparam int WIDTH = 16;
  localparam int CNT_W = 32;
  localparam int ACC_W = 48;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic in_valid = 1'b0;
  logic [WIDTH-1:0] in_a = '0, in_b = '0;
  logic [WIDTH:0] in_approx = '0;

  logic in_ready, busy, done, acc_ovf;
  logic [CNT_W-1:0] sample_cnt, err_cnt;
  logic [WIDTH:0] max_abs_err;
  logic [ACC_W-1:0] sum_abs_err;

  logic s_ready, s_busy, s_done, s_ovf;
  logic [CNT_W-1:0] s_cnt, s_err;
  logic [WIDTH:0] s_max;
  logic [16:0] s_sum;
`ifdef APPROX_ERR_MONITOR_WCE_EN
  logic [WIDTH-1:0] wce_a, wce_b, s_wa, s_wb;
  logic [WIDTH:0] wce_approx, s_wap;
`endif

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(ACC_W)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(busy), .done(done), .sample_cnt(sample_cnt),
    .err_cnt(err_cnt), .max_abs_err(max_abs_err), .sum_abs_err(sum_abs_err),
    .acc_ovf(acc_ovf)
`ifdef APPROX_ERR_MONITOR_WCE_EN
    , .wce_a(wce_a), .wce_b(wce_b), .wce_approx(wce_approx)
`endif
  );

  approx_err_monitor #(.WIDTH(WIDTH), .CNT_W(CNT_W), .ACC_W(17)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_ready), .in_a(in_a), .in_b(in_b),
    .in_approx(in_approx), .busy(s_busy), .done(s_done), .sample_cnt(s_cnt),
    .err_cnt(s_err), .max_abs_err(s_max), .sum_abs_err(s_sum),
    .acc_ovf(s_ovf)
`ifdef APPROX_ERR_MONITOR_WCE_EN
    , .wce_a(s_wa), .wce_b(s_wb), .wce_approx(s_wap)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_samples = CNT_W'(n);
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                      input logic [WIDTH:0] ap);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_approx = ap;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 20 && !done; i++) tick();
    if (!done) chk({tag, "_timeout"}, 64'(done), 64'd1);
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_stats", 64'(sample_cnt) | 64'(err_cnt) | 64'(max_abs_err) | 64'(sum_abs_err) | 64'(acc_ovf), 64'd0);
    #9 rst_n = 1'b1;
    tick();

    // exact-only window
    do_start(3);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ready", 64'(in_ready), 64'd1);
    send(16'd1, 16'd2, 17'd3);
    send(16'hFFFF, 16'd1, 17'h10000);
    send(16'd5, 16'd5, 17'd10);
    wait_done("t1");
    chk("t1_cnt", 64'(sample_cnt), 64'd3);
    chk("t1_err", 64'(err_cnt), 64'd0);
    chk("t1_max", 64'(max_abs_err), 64'd0);
    chk("t1_sum", 64'(sum_abs_err), 64'd0);

    // mixed signs; also proves start clears old stats
    do_start(3);
    chk("t2_clr", 64'(sample_cnt), 64'd0);
    send(16'd0, 16'd0, 17'h08000);
    send(16'd3, 16'd4, 17'd5);
    send(16'd10, 16'd10, 17'd20);
    wait_done("t2");
    chk("t2_cnt", 64'(sample_cnt), 64'd3);
    chk("t2_err", 64'(err_cnt), 64'd2);
    chk("t2_max", 64'(max_abs_err), 64'h08000);
    chk("t2_sum", 64'(sum_abs_err), 64'h08002);
`ifdef APPROX_ERR_MONITOR_WCE_EN
    chk("t2_wce_a", 64'(wce_a), 64'd0);
    chk("t2_wce_b", 64'(wce_b), 64'd0);
    chk("t2_wce_ap", 64'(wce_approx), 64'h08000);
`endif

    // handshake: in_valid held 5 cycles, start pulsed mid-RUN
    do_start(2);
    in_a = 16'd1; in_b = 16'd1; in_approx = 17'd3;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      start = (i == 0);
      num_samples = 32'd7;
      tick();
      start = 1'b0;
      case (i)
        0: chk("hs_ready1", 64'(in_ready), 64'd1);
        1: begin
          chk("hs_ready_fall", 64'(in_ready), 64'd0);
          chk("hs_drain_busy", 64'(busy), 64'd0);
          chk("hs_drain_done", 64'(done), 64'd0);
        end
        2: chk("hs_done_early", 64'(done), 64'd0);
        3: chk("hs_done", 64'(done), 64'd1);
        default: chk("hs_ready_done", 64'(in_ready), 64'd0);
      endcase
    end
    in_valid = 1'b0;
    chk("hs_cnt", 64'(sample_cnt), 64'd2);
    chk("hs_err", 64'(err_cnt), 64'd2);
    chk("hs_sum", 64'(sum_abs_err), 64'd2);
    chk("hs_max_tie", 64'(max_abs_err), 64'd1);

    // zero-length window
    in_valid = 1'b1;
    do_start(0);
    chk("z_done", 64'(done), 64'd1);
    chk("z_ready", 64'(in_ready), 64'd0);
    tick();
    in_valid = 1'b0;
    chk("z_stats", 64'(sample_cnt) | 64'(err_cnt) | 64'(max_abs_err) | 64'(sum_abs_err), 64'd0);

    // saturation on the ACC_W=17 instance
    do_start(2);
    send(16'd0, 16'd0, 17'h1FFFF);
    send(16'd0, 16'd0, 17'h1FFFF);
    wait_done("sat");
    chk("sat_sum", 64'(s_sum), 64'h1FFFF);
    chk("sat_ovf", 64'(s_ovf), 64'd1);
    chk("wide_sum", 64'(sum_abs_err), 64'h3FFFE);
    chk("wide_ovf", 64'(acc_ovf), 64'd0);
    do_start(0);
    chk("sat_ovf_clr", 64'(s_ovf), 64'd0);

    // reset mid-RUN
    do_start(4);
    send(16'd0, 16'd0, 17'd5);
    tick();
    chk("mr_cnt_pre", 64'(sample_cnt), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_cnt", 64'(sample_cnt), 64'd0);
    chk("mr_sum", 64'(sum_abs_err), 64'd0);
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ready", 64'(in_ready), 64'd0);
    #3 rst_n = 1'b1;
    tick();
    do_start(1);
    send(16'd2, 16'd2, 17'd4);
    wait_done("mr2");
    chk("mr2_cnt", 64'(sample_cnt), 64'd1);
    chk("mr2_err", 64'(err_cnt), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/approx_err_monitor.md
Name: approx_err_monitor

Overview:
- Streaming error-statistics collector placed directly downstream of a WIDTH-bit approximate adder under evaluation.
- Each sample carries the adder operands and the adder's (WIDTH+1)-bit approximate sum. The block computes the exact sum and the absolute error, then accumulates the statistics over a programmed sample window:
  - sample count
  - erroneous-sample count
  - maximum absolute error
  - sum of absolute errors
- Results feed software/testbench MAE and worst-case-error reporting.

Parameters:
- WIDTH, 16, operand width; sums and errors are WIDTH+1 bits.
- CNT_W, 32, width of the sample and error counters and of num_samples.
- ACC_W, 48, width of the absolute-error accumulator.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle pulse; clears statistics, latches num_samples, begins a window.
- num_samples  in  CNT_W  window length; sampled only on accepted start.
- in_valid  in  1  sample valid.
- in_ready  out  1  block accepts a sample this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_approx  in  WIDTH+1  approximate sum for (in_a, in_b).
- busy  out  1  high in RUN.
- done  out  1  level; high in DONE.
- sample_cnt  out  CNT_W  samples accounted into statistics.
- err_cnt  out  CNT_W  samples with nonzero error.
- max_abs_err  out  WIDTH+1  largest absolute error in the window.
- sum_abs_err  out  ACC_W  sum of absolute errors, saturating.
- acc_ovf  out  1  sticky; sum_abs_err saturated.

Behaviour:
- Reset: state IDLE; every output and the pipeline registers are 0; in_ready is 0.
- FSM states are IDLE, RUN, DAIN, DONE.
  - IDLE, start: go to RUN. If num_samples==0, go to DONE instead.
  - RUN: stays until the accepted count reaches num_samples, then goes to DRAIN.
  - DRAIN: stays until both pipeline stages are empty (2 cycles), then goes to DONE.
  - DONE, start: behaves exactly like start in IDLE.
  - start in RUN or DRAIN is ignored.
- On an accepted start:
  - sample_cnt, err_cnt, max_abs_err, sum_abs_err and acc_ovf clear on the next edge.
  - num_samples is latched.
- in_ready = (state==RUN) && (accepted < latched num_samples). It is combinational from state and counters only, never from in_valid.
- Acceptance is in_valid && in_ready. Samples presented while in_ready is low are neither counted nor stored.
- Pipeline:
  - Stage 1 registers exact = zero-extended in_a + in_b (WIDTH+1 bits) together with in_approx.
  - Stage 2 computes abs_err = |approx − exact| (WIDTH+1 bits, no wrap) and updates all statistics.
  - Statistics therefore reflect a sample at the second rising edge after acceptance.
  - Back-to-back acceptance at 1 sample per cycle is supported.
- err_cnt increments only when abs_err != 0.
- max_abs_err updates only on a strictly greater value; a tie keeps the existing value.
- sum_abs_err adds zero-extended abs_err.
  - On carry-out it saturates to all-ones and sets acc_ovf.
  - acc_ovf stays set until the next start or reset.
- Outputs hold their values in DONE until a new start.
- Reset mid-window: all state is discarded immediately (asynchronous) and every output returns to 0.

Optional Feature:
- Macro: APPROX_ERR_MONITOR_WCE_EN.
- Defined: adds outputs wce_a (WIDTH), wce_b (WIDTH) and wce_approx (WIDTH+1).
  - They record the operands and approximate sum of the sample that last updated max_abs_err.
  - They are 0 on reset and on start, and update in the same cycle as max_abs_err.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Exact-only window: num_samples=3, samples (1,2,3), (0xFFFF,1,0x10000), (5,5,10) -> done; sample_cnt=3, err_cnt=0, max_abs_err=0, sum_abs_err=0.
- Mixed errors, both signs: samples (0,0,0x08000), (3,4,5), (10,10,20) -> err_cnt=2, max_abs_err=0x08000, sum_abs_err=0x08002. With WCE_EN: wce_a=0, wce_b=0, wce_approx=0x08000.
- Handshake:
  - num_samples=2 with in_valid held high for 5 cycles -> exactly 2 accepted; in_ready falls the cycle after the second acceptance.
  - done rises 2 cycles after DRAIN entry.
  - start pulsed in RUN has no effect.
- num_samples=0 -> done the cycle after start; all statistics 0; in_ready never asserts.
- Saturation (ACC_W=17 build): two samples each with abs_err=0x1FFFF -> sum_abs_err=0x1FFFF, acc_ovf=1. A following start clears acc_ovf.
- Reset mid-RUN after 1 accepted sample -> all outputs 0 immediately. After release, start with num_samples=1 and one sample -> sample_cnt=1.
